// File: rtl/riscv_pkg.sv
// Shared RV32 constants and types for the instruction fetch front end.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [ILEN-1:0] NOP              = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus: redirect input, instruction memory read port, decode handshake.
interface instr_fetch_unit_if
  import riscv_pkg::*;
();

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;

  logic            out_valid;
  logic [ILEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic            out_ready;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output out_valid, out_instr, out_pc,
    input  out_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  out_valid, out_instr, out_pc,
    output out_ready
  );

endinterface

// File: rtl/instr_fetch_unit_sync_fifo.sv
// Register-based FIFO whose read port shows the head, or the last head seen once it drains.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] last_q;
  logic             do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign do_pop = pop && !empty;
  assign rdata  = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  // Shadow of the head so the output holds its last value when the buffer empties.
  always_ff @(posedge clk) begin
    if (rst)         last_q <= '0;
    else if (!empty) last_q <= mem[rd_ptr];
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC generation, credit-limited pipelined imem reads,
// redirect flush with stale-response discard, and a {pc, instr} buffer toward decode.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  resp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard;
  logic             rst_cycle;

  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credit_used;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             gnt_fire;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

  // Words already in the buffer plus reads in flight may never exceed DEPTH.
  assign credit_used   = {1'b0, fifo_count} + {1'b0, outstanding};
  assign bus.imem_req  = !rst_cycle && !bus.redirect_valid &&
                         (credit_used < (CNT_W+1)'(DEPTH));
  assign bus.imem_addr = fetch_pc;
  assign gnt_fire      = bus.imem_req && bus.imem_gnt;

  assign fifo_push  = bus.imem_rvalid && !bus.redirect_valid && (discard == '0);
  assign fifo_pop   = bus.out_valid && bus.out_ready && !bus.redirect_valid;
  assign push_entry = '{pc: resp_pc, instr: bus.imem_rdata};

  assign bus.out_valid = !fifo_empty;
  assign bus.out_pc    = head_entry.pc;
  assign bus.out_instr = head_entry.instr;

  always_ff @(posedge clk) begin
    rst_cycle <= rst;
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc    <= align_pc(bus.redirect_pc);
      resp_pc     <= align_pc(bus.redirect_pc);
      outstanding <= outstanding - CNT_W'(bus.imem_rvalid);
      discard     <= outstanding - CNT_W'(bus.imem_rvalid);
    end else begin
      if (gnt_fire) fetch_pc <= fetch_pc + PC_STEP;
      outstanding <= outstanding + CNT_W'(gnt_fire) - CNT_W'(bus.imem_rvalid);
      if (bus.imem_rvalid) begin
        if (discard != '0) discard <= discard - CNT_W'(1);
        else               resp_pc <= resp_pc + PC_STEP;
      end
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (bus.redirect_valid),
    .wdata (push_entry),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) fifo_push |-> !fifo_full);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with an in-order, variable-latency imem model.
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  logic clk;
  logic rst;
  instr_fetch_unit_if bus();

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mem_lat = 1;
  int hs_cnt = 0;
  int gnt_cnt = 0;
  logic [31:0] exp_fetch = RST_PC;
  exp_t  exp_q[$];
  mreq_t mem_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a << 5) ^ NOP ^ 32'hA500_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model: record grants and consumed words at the negative edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      mem_q.delete();
      exp_fetch = RST_PC;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("out_pc", bus.out_pc, e.pc);
          chk("out_instr", bus.out_instr, e.instr);
        end
      end
      if (bus.redirect_valid) begin
        chk("req_in_redirect", {31'd0, bus.imem_req}, 32'd0);
        exp_q.delete();
        exp_fetch = bus.redirect_pc & ~32'h3;
      end else if (bus.imem_req && bus.imem_gnt) begin
        gnt_cnt++;
        chk("fetch_addr", bus.imem_addr, exp_fetch);
        exp_q.push_back('{pc: exp_fetch, instr: instr_of(exp_fetch)});
        mem_q.push_back('{addr: bus.imem_addr, due: cyc + mem_lat});
        exp_fetch = exp_fetch + 32'd4;
      end
    end
  end

  // Memory response driver: in order, each no earlier than its due cycle.
  always @(posedge clk) begin
    mreq_t m;
    #1;
    cyc++;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = instr_of(m.addr);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = NOP;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int h0;
    int g0;
    bit found;
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_gnt       = 1'b1;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = NOP;
    bus.out_ready      = 1'b1;

    // Reset state and release latency
    step(); step();
    @(negedge clk);
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, RST_PC);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    step(); rst = 1'b0;
    @(negedge clk); chk("lat_T_req", {31'd0, bus.imem_req}, 32'd0);
    @(negedge clk); chk("lat_T1_req", {31'd0, bus.imem_req}, 32'd1);
    @(negedge clk); chk("lat_T2_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk); chk("lat_T3_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("lat_T3_pc", bus.out_pc, RST_PC);
    h0 = hs_cnt;
    repeat (10) @(negedge clk);
    chk("throughput", hs_cnt - h0, 32'd10);

    // Decode stall from reset: buffer and credits fill, then fetch stops
    step(); rst = 1'b1; bus.out_ready = 1'b0;
    step(); rst = 1'b0;
    g0 = gnt_cnt;
    repeat (20) @(negedge clk);
    chk("stall_gnts", gnt_cnt - g0, 32'd4);
    chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
    chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("stall_head_pc", bus.out_pc, RST_PC);
    step(); bus.out_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("stall_resume", {31'd0, (gnt_cnt - g0) > 4}, 32'd1);

    // Grant withheld: request and address hold
    step(); bus.imem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_req", {31'd0, bus.imem_req}, 32'd1);
      chk("hold_addr", bus.imem_addr, exp_fetch);
    end
    step(); bus.imem_gnt = 1'b1;
    repeat (10) @(negedge clk);

    // Redirect with two reads in flight
    step(); mem_lat = 2;
    repeat (6) @(negedge clk);
    step(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40;
    step(); bus.redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.out_valid) found = 1'b1;
    end
    chk("redir_found", {31'd0, found}, 32'd1);
    chk("redir_pc0", bus.out_pc, 32'h40);
    @(negedge clk); chk("redir_pc1", bus.out_pc, 32'h44);

    // Redirect coinciding with a response and a pop
    step(); mem_lat = 1;
    repeat (6) @(negedge clk);
    step(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h102;
    @(negedge clk); chk("r5_pop_valid", {31'd0, bus.out_valid}, 32'd1);
    step(); bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("r5_empty", {31'd0, bus.out_valid}, 32'd0);
    chk("r5_addr", bus.imem_addr, 32'h100);
    chk("r5_req", {31'd0, bus.imem_req}, 32'd1);
    repeat (8) @(negedge clk);

    // PC wrap across the top of the address space
    step(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFF9;
    step(); bus.redirect_valid = 1'b0;
    repeat (10) @(negedge clk);

    // Reset with a loaded buffer and reads in flight
    step(); bus.out_ready = 1'b0; mem_lat = 3;
    repeat (6) @(negedge clk);
    chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    step(); rst = 1'b1;
    step(); rst = 1'b0; bus.out_ready = 1'b1; mem_lat = 1;
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("mid_rst_addr", bus.imem_addr, RST_PC);
    chk("mid_rst_out_pc", bus.out_pc, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.out_valid) found = 1'b1;
    end
    chk("restart_found", {31'd0, found}, 32'd1);
    chk("restart_pc", bus.out_pc, RST_PC);
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
